// File: rtl/bp_cce_pkg.sv
// Shared CCE types for the LCE command port arbiter.
package bp_cce_pkg;

    typedef enum logic {
        eArb,
        eLocked
    } bp_cce_lce_cmd_arb_state_e;

    typedef enum logic {
        eSrcUcode,
        eSrcMsg
    } bp_cce_lce_cmd_src_e;

    function automatic bp_cce_lce_cmd_src_e other_src(input bp_cce_lce_cmd_src_e s);
        return (s == eSrcUcode) ? eSrcMsg : eSrcUcode;
    endfunction

endpackage

// File: rtl/bp_cce_lce_cmd_arb_burst_cnt.sv
// Remaining-beat counter for a Message Unit burst: load, decrement, zero/last flags.
module bp_cce_lce_cmd_arb_burst_cnt #(
    parameter int unsigned width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o,
    output logic               last_o
);

    logic [width_p-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    // Set when the next accepted beat is the final beat of the burst.
    assign last_o = (cnt_q == width_p'(1));

endmodule

// File: rtl/bp_cce_lce_cmd_arbiter.sv
// Round-robin arbiter sharing the outbound LCE command port between microcode sends and
// Message Unit bursts; the port stays locked to one owner until its beat/burst is accepted.
module bp_cce_lce_cmd_arbiter
    import bp_cce_pkg::*;
#(
    parameter int unsigned lce_cmd_width_p = 64,
    parameter int unsigned max_beats_p     = 8,
    localparam int unsigned lg_max_beats_lp = $clog2(max_beats_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       ucode_v_i,
    input  logic [lce_cmd_width_p-1:0] ucode_cmd_i,
    output logic                       ucode_yumi_o,

    input  logic                       msg_v_i,
    input  logic [lce_cmd_width_p-1:0] msg_cmd_i,
    input  logic [lg_max_beats_lp-1:0] msg_len_i,
    output logic                       msg_yumi_o,

    output logic                       lce_cmd_v_o,
    output logic [lce_cmd_width_p-1:0] lce_cmd_o,
    input  logic                       lce_cmd_ready_i,

    output logic                       msg_lce_cmd_busy_o
);

    bp_cce_lce_cmd_arb_state_e state_q, state_d;
    bp_cce_lce_cmd_src_e       owner_q, owner_d;
    bp_cce_lce_cmd_src_e       last_q, last_d;
    logic                      first_q, first_d;

    bp_cce_lce_cmd_src_e       arb_win;
    bp_cce_lce_cmd_src_e       grant;
    logic                      port_v;
    logic                      busy;
    logic                      accept;

    logic                       cnt_load;
    logic [lg_max_beats_lp-1:0] cnt_load_val;
    logic                       cnt_dec;
    logic                       cnt_zero;
    logic                       cnt_last;

    bp_cce_lce_cmd_arb_burst_cnt #(
        .width_p(lg_max_beats_lp)
    ) u_burst_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero),
        .last_o    (cnt_last)
    );

    always_comb begin
        if (ucode_v_i && msg_v_i) begin
            arb_win = other_src(last_q);
        end else if (msg_v_i) begin
            arb_win = eSrcMsg;
        end else begin
            arb_win = eSrcUcode;
        end
    end

    assign accept = port_v & lce_cmd_ready_i & reset_n_i;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        first_d      = first_q;
        cnt_load     = 1'b0;
        cnt_load_val = msg_len_i;
        cnt_dec      = 1'b0;
        grant        = eSrcUcode;
        port_v       = 1'b0;
        busy         = 1'b0;

        unique case (state_q)
            eArb: begin
                grant  = arb_win;
                port_v = ucode_v_i | msg_v_i;
                busy   = (arb_win == eSrcMsg) & msg_v_i;
                if (port_v) begin
                    if (lce_cmd_ready_i) begin
                        last_d = arb_win;
                        if ((arb_win == eSrcMsg) && (msg_len_i != '0)) begin
                            state_d  = eLocked;
                            owner_d  = eSrcMsg;
                            first_d  = 1'b0;
                            cnt_load = 1'b1;
                        end
                    end else begin
                        // Freeze the grant while the offer is pending; length is taken later.
                        state_d      = eLocked;
                        owner_d      = arb_win;
                        first_d      = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = '0;
                    end
                end
            end
            eLocked: begin
                grant  = owner_q;
                port_v = (owner_q == eSrcMsg) ? msg_v_i : ucode_v_i;
                busy   = (owner_q == eSrcMsg);
                if (port_v && lce_cmd_ready_i) begin
                    if (first_q && ((owner_q == eSrcUcode) || (msg_len_i == '0))) begin
                        state_d = eArb;
                        last_d  = owner_q;
                        first_d = 1'b0;
                    end else if (first_q) begin
                        first_d  = 1'b0;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                        if (cnt_last) begin
                            state_d = eArb;
                            last_d  = owner_q;
                        end
                    end
                end
            end
            default: begin
                state_d = eArb;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eArb;
            owner_q <= eSrcUcode;
            last_q  <= eSrcMsg;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    assign lce_cmd_v_o        = port_v & reset_n_i;
    assign lce_cmd_o          = (grant == eSrcMsg) ? msg_cmd_i : ucode_cmd_i;
    assign ucode_yumi_o       = accept & (grant == eSrcUcode);
    assign msg_yumi_o         = accept & (grant == eSrcMsg);
    assign msg_lce_cmd_busy_o = busy & reset_n_i;

    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(ucode_yumi_o && msg_yumi_o));

    a_len_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        msg_yumi_o |-> (int'(msg_len_i) < int'(max_beats_p)));

    // Mid-burst the counter always holds at least the final beat.
    a_burst_cnt: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q == eLocked && !first_q) |-> !cnt_zero);

endmodule

// File: tb/tb_bp_cce_lce_cmd_arbiter.sv
// Directed table-driven bench for the LCE command port arbiter.
module tb_bp_cce_lce_cmd_arbiter;

    localparam int unsigned W = 64;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ucode_v = 1'b0;
    logic [W-1:0]  ucode_cmd = '0;
    logic          ucode_yumi;
    logic          msg_v = 1'b0;
    logic [W-1:0]  msg_cmd = '0;
    logic [LW-1:0] msg_len = '0;
    logic          msg_yumi;
    logic          lce_cmd_v;
    logic [W-1:0]  lce_cmd;
    logic          ready = 1'b0;
    logic          busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bp_cce_lce_cmd_arbiter #(
        .lce_cmd_width_p(W),
        .max_beats_p    (8)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .ucode_v_i         (ucode_v),
        .ucode_cmd_i       (ucode_cmd),
        .ucode_yumi_o      (ucode_yumi),
        .msg_v_i           (msg_v),
        .msg_cmd_i         (msg_cmd),
        .msg_len_i         (msg_len),
        .msg_yumi_o        (msg_yumi),
        .lce_cmd_v_o       (lce_cmd_v),
        .lce_cmd_o         (lce_cmd),
        .lce_cmd_ready_i   (ready),
        .msg_lce_cmd_busy_o(busy)
    );

    typedef struct {
        logic          rst_n;
        logic          uv;
        logic [W-1:0]  ucmd;
        logic          mv;
        logic [W-1:0]  mcmd;
        logic [LW-1:0] len;
        logic          rdy;
        logic          ev;
        logic [W-1:0]  ecmd;
        logic          euy;
        logic          emy;
        logic          ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic uv, input logic [W-1:0] ucmd,
                                input logic mv, input logic [W-1:0] mcmd, input logic [LW-1:0] len,
                                input logic rdy, input logic ev, input logic [W-1:0] ecmd,
                                input logic euy, input logic emy, input logic ebusy);
        vec_t v;
        v.rst_n = r;  v.uv = uv;   v.ucmd = ucmd; v.mv = mv;   v.mcmd = mcmd; v.len = len;
        v.rdy = rdy;  v.ev = ev;   v.ecmd = ecmd; v.euy = euy; v.emy = emy;   v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply_and_check(input vec_t v, input int idx);
        @(negedge clk);
        reset_n   = v.rst_n;
        ucode_v   = v.uv;
        ucode_cmd = v.ucmd;
        msg_v     = v.mv;
        msg_cmd   = v.mcmd;
        msg_len   = v.len;
        ready     = v.rdy;
        #1;
        check("lce_cmd_v", idx, W'(lce_cmd_v), W'(v.ev));
        if (v.ev) check("lce_cmd", idx, lce_cmd, v.ecmd);
        check("ucode_yumi", idx, W'(ucode_yumi), W'(v.euy));
        check("msg_yumi", idx, W'(msg_yumi), W'(v.emy));
        check("busy", idx, W'(busy), W'(v.ebusy));
        check("yumi_excl", idx, W'(ucode_yumi & msg_yumi), '0);
    endtask

    initial begin
        //              rst uv ucmd    mv mcmd    len rdy  ev ecmd    uy my busy
        // Reset with everything requesting: outputs forced idle.
        vecs.push_back(mk(0, 1, 64'hA5,  1, 64'hB0,  0, 1,  0, 64'h0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 64'hA5,  1, 64'hB0,  0, 1,  0, 64'h0,  0, 0, 0));
        // Lone ucode, same-cycle accept, stays in arbitration.
        vecs.push_back(mk(1, 1, 64'hA5,  0, 64'hB0,  0, 1,  1, 64'hA5, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'h5A,  0, 64'hB0,  0, 1,  1, 64'h5A, 1, 0, 0));
        // Fresh reset, then both valid with len 0: ucode, msg, ucode, msg.
        vecs.push_back(mk(0, 0, 64'h0,   0, 64'h0,   0, 0,  0, 64'h0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA1,  1, 64'hB1,  0, 1,  1, 64'hA1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA1,  1, 64'hB1,  0, 1,  1, 64'hB1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA1,  1, 64'hB1,  0, 1,  1, 64'hA1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA1,  1, 64'hB1,  0, 1,  1, 64'hB1, 0, 1, 1));
        // len=3 burst with ucode contending: ucode (its turn), 4 msg beats, then ucode.
        vecs.push_back(mk(1, 1, 64'hA2,  1, 64'hC0,  3, 1,  1, 64'hA2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA2,  1, 64'hC0,  3, 1,  1, 64'hC0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA2,  1, 64'hC1,  3, 1,  1, 64'hC1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA2,  1, 64'hC2,  3, 1,  1, 64'hC2, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA2,  1, 64'hC3,  3, 1,  1, 64'hC3, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA3,  1, 64'hC4,  3, 1,  1, 64'hA3, 1, 0, 0));
        // ucode stalled 3 cycles, msg arrives in cycle 2: grant frozen, then msg.
        vecs.push_back(mk(1, 1, 64'hA4,  0, 64'hB2,  0, 0,  1, 64'hA4, 0, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA4,  1, 64'hB2,  0, 0,  1, 64'hA4, 0, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA4,  1, 64'hB2,  0, 0,  1, 64'hA4, 0, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA4,  1, 64'hB2,  0, 1,  1, 64'hA4, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA9,  1, 64'hB2,  0, 1,  1, 64'hB2, 0, 1, 1));
        // len=2 burst with a 2-cycle msg bubble; ucode must wait.
        vecs.push_back(mk(1, 1, 64'hA5,  1, 64'hD0,  2, 1,  1, 64'hA5, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA5,  1, 64'hD0,  2, 1,  1, 64'hD0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA5,  0, 64'hD1,  2, 1,  0, 64'h0,  0, 0, 1));
        vecs.push_back(mk(1, 1, 64'hA5,  0, 64'hD1,  2, 1,  0, 64'h0,  0, 0, 1));
        vecs.push_back(mk(1, 1, 64'hA5,  1, 64'hD1,  2, 1,  1, 64'hD1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA5,  1, 64'hD2,  2, 1,  1, 64'hD2, 0, 1, 1));
        vecs.push_back(mk(1, 1, 64'hA6,  0, 64'hD3,  2, 1,  1, 64'hA6, 1, 0, 0));
        // Reset during beat 2 of a len=4 burst: burst abandoned, ucode wins next tie.
        vecs.push_back(mk(1, 1, 64'hA7,  1, 64'hE0,  4, 1,  1, 64'hE0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 64'hA7,  1, 64'hE1,  4, 1,  0, 64'h0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA7,  1, 64'hE1,  4, 1,  1, 64'hA7, 1, 0, 0));
        vecs.push_back(mk(1, 1, 64'hA8,  1, 64'hE9,  0, 1,  1, 64'hE9, 0, 1, 1));

        foreach (vecs[i]) apply_and_check(vecs[i], i);

        // Message stalled on its first beat, then a len=1 burst; length taken at first accept.
        begin
            vec_t v;
            v = mk(1, 0, 64'hAA, 1, 64'hF0, 1, 0, 1, 64'hF0, 0, 0, 1);
            apply_and_check(v, 100);
            v = mk(1, 1, 64'hAA, 1, 64'hF0, 1, 0, 1, 64'hF0, 0, 0, 1);
            apply_and_check(v, 101);
            v = mk(1, 1, 64'hAA, 1, 64'hF0, 1, 1, 1, 64'hF0, 0, 1, 1);
            apply_and_check(v, 102);
            v = mk(1, 1, 64'hAA, 1, 64'hF1, 5, 1, 1, 64'hF1, 0, 1, 1);
            apply_and_check(v, 103);
            v = mk(1, 1, 64'hAB, 0, 64'hF2, 0, 1, 1, 64'hAB, 1, 0, 0);
            apply_and_check(v, 104);
        end

        // Stalled ucode released by ready; no second beat without a new valid.
        begin
            vec_t v;
            v = mk(1, 1, 64'hAC, 0, 64'h0, 0, 0, 1, 64'hAC, 0, 0, 0);
            apply_and_check(v, 200);
            v = mk(1, 1, 64'hAC, 0, 64'h0, 0, 1, 1, 64'hAC, 1, 0, 0);
            apply_and_check(v, 201);
            v = mk(1, 0, 64'hAC, 0, 64'h0, 0, 1, 0, 64'h0, 0, 0, 0);
            apply_and_check(v, 202);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
